// File: rtl/design_sel_pkg.sv
// Shared definitions for the design-select sequencer and the design mux.
package design_sel_pkg;

    localparam int unsigned ID_W = 4;
    localparam logic [ID_W-1:0] PARK_ID_DEF = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        PARK_SET,
        PARK_CLK,
        QUIESCE,
        SEL_SET,
        SEL_CLK,
        HOLD
    } sel_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/design_sel_ctrl.sv
// Design-select sequencer: parks the pads, holds every design in reset,
// captures the new id into the mux, then releases only the chosen design.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | outputs held; waits for a request edge or a pending request
//   PARK_SET | all designs in reset, sel_id driven to PARK_ID
//   PARK_CLK | sel_clk pulse captures PARK_ID
//   QUIESCE  | QUIESCE_CYCLES wait; out-of-range target ends here parked
//   SEL_SET  | sel_id driven to target
//   SEL_CLK  | sel_clk pulse captures target
//   HOLD     | HOLD_CYCLES wait, then target released from reset
module design_sel_ctrl
    import design_sel_pkg::*;
#(
    parameter int unsigned     NUM_DESIGNS    = 4,
    parameter int unsigned     QUIESCE_CYCLES = 16,
    parameter int unsigned     HOLD_CYCLES    = 16,
    parameter logic [ID_W-1:0] PARK_ID        = PARK_ID_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n,
    input  logic                   la_req,
    input  logic [ID_W-1:0]        la_id,
    output logic                   sel_clk,
    output logic [ID_W-1:0]        sel_id,
    output logic [NUM_DESIGNS-1:0] design_rst_n,
    output logic                   busy,
    output logic [ID_W-1:0]        active_id
);

    localparam int unsigned CNT_MAX = max_u(QUIESCE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX == 0) ? 1 : $clog2(CNT_MAX + 1);
    // A zero-length wait still spends one cycle in its state.
    localparam int unsigned Q_LOAD  = (QUIESCE_CYCLES == 0) ? 0 : QUIESCE_CYCLES - 1;
    localparam int unsigned H_LOAD  = (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;
    localparam logic [NUM_DESIGNS-1:0] RST_ONE = NUM_DESIGNS'(1);

    sel_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  target;
    logic [ID_W-1:0]  pending_id;
    logic             pending_valid;
    logic             req_s1;
    logic             req_s2;
    logic [ID_W-1:0]  id_s;
    logic             req_edge;
    logic             tgt_valid;

    sync_2ff #(.W(1)) u_sync_req (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .d     (la_req),
        .q     (req_s1)
    );

    sync_2ff #(.W(ID_W)) u_sync_id (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .d     (la_id),
        .q     (id_s)
    );

    assign req_edge  = req_s1 & ~req_s2;
    assign tgt_valid = (32'(target) < NUM_DESIGNS);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            target        <= PARK_ID;
            pending_id    <= PARK_ID;
            pending_valid <= 1'b0;
            req_s2        <= 1'b0;
            sel_clk       <= 1'b0;
            sel_id        <= PARK_ID;
            design_rst_n  <= '0;
            busy          <= 1'b0;
            active_id     <= PARK_ID;
        end else begin
            req_s2 <= req_s1;

            // Requests arriving mid-sequence queue up; the newest one wins.
            if (state != IDLE && req_edge) begin
                pending_id    <= id_s;
                pending_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_edge || pending_valid) begin
                        target        <= req_edge ? id_s : pending_id;
                        pending_valid <= 1'b0;
                        busy          <= 1'b1;
                        design_rst_n  <= '0;
                        sel_id        <= PARK_ID;
                        active_id     <= PARK_ID;
                        state         <= PARK_SET;
                    end
                end
                PARK_SET: begin
                    sel_clk <= 1'b1;
                    state   <= PARK_CLK;
                end
                PARK_CLK: begin
                    sel_clk <= 1'b0;
                    cnt     <= CNT_W'(Q_LOAD);
                    state   <= QUIESCE;
                end
                QUIESCE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (tgt_valid) begin
                        sel_id <= target;
                        state  <= SEL_SET;
                    end else begin
                        busy      <= 1'b0;
                        active_id <= PARK_ID;
                        state     <= IDLE;
                    end
                end
                SEL_SET: begin
                    sel_clk <= 1'b1;
                    state   <= SEL_CLK;
                end
                SEL_CLK: begin
                    sel_clk <= 1'b0;
                    cnt     <= CNT_W'(H_LOAD);
                    state   <= HOLD;
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        design_rst_n <= RST_ONE << target;
                        active_id    <= target;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_design_sel_ctrl.sv
// Bench for design_sel_ctrl: directed scenarios plus random requests, checked
// every cycle against a timeline model of each switch sequence.
module tb_design_sel_ctrl;

    localparam int ND = 4;
    localparam int QC = 16;
    localparam int HC = 16;
    localparam logic [3:0] PARK = 4'hF;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n = 1'b0;
    logic          la_req   = 1'b0;
    logic [3:0]    la_id    = 4'h0;
    logic          sel_clk;
    logic [3:0]    sel_id;
    logic [ND-1:0] design_rst_n;
    logic          busy;
    logic [3:0]    active_id;

    design_sel_ctrl #(
        .NUM_DESIGNS    (ND),
        .QUIESCE_CYCLES (QC),
        .HOLD_CYCLES    (HC),
        .PARK_ID        (PARK)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n     (wb_rst_n),
        .la_req       (la_req),
        .la_id        (la_id),
        .sel_clk      (sel_clk),
        .sel_id       (sel_id),
        .design_rst_n (design_rst_n),
        .busy         (busy),
        .active_id    (active_id)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Model: each accepted request becomes a sequence starting at cycle S
    // (two cycles after la_req is seen high at a clock edge, plus one).
    bit            mon_en = 1'b0;
    int            dq_d[$];
    logic [3:0]    dq_id[$];
    bit            running = 1'b0;
    bit            pend_v  = 1'b0;
    logic [3:0]    pend_id = 4'h0;
    int            seq_s = 0;
    int            seq_e = 0;
    logic [3:0]    seq_tgt = 4'h0;
    bit            seq_ok = 1'b0;
    logic [ND-1:0] rel_rst = '0;
    logic [3:0]    rel_active = PARK;
    logic [3:0]    rel_sel = PARK;

    int  pulse_cnt = 0;
    bit  t4_phase = 1'b0;
    bit  seen3 = 1'b0;

    task automatic start_seq(input int c, input logic [3:0] id);
        running = 1'b1;
        pend_v  = 1'b0;
        seq_s   = c + 1;
        seq_tgt = id;
        seq_ok  = (int'(id) < ND);
        seq_e   = seq_ok ? seq_s + 4 + QC + HC : seq_s + 2 + QC;
    endtask

    task automatic model_step();
        int            c;
        bit            edge_now;
        logic [3:0]    edge_id;
        logic          e_busy, e_clk;
        logic [ND-1:0] e_rst;
        logic [3:0]    e_act, e_sel;
        c        = cyc;
        edge_now = 1'b0;
        edge_id  = 4'h0;
        if (running && c == seq_e) begin
            running = 1'b0;
            if (seq_ok) begin
                rel_rst    = ND'(1) << seq_tgt;
                rel_active = seq_tgt;
                rel_sel    = seq_tgt;
            end else begin
                rel_rst    = '0;
                rel_active = PARK;
                rel_sel    = PARK;
            end
        end
        if (dq_d.size() > 0 && dq_d[0] == c) begin
            edge_now = 1'b1;
            edge_id  = dq_id[0];
            void'(dq_d.pop_front());
            void'(dq_id.pop_front());
        end
        if (running) begin
            e_busy = 1'b1;
            e_rst  = '0;
            e_act  = PARK;
            e_clk  = (c == seq_s + 1) || (seq_ok && c == seq_s + 3 + QC);
            e_sel  = (seq_ok && c >= seq_s + 2 + QC) ? seq_tgt : PARK;
        end else begin
            e_busy = 1'b0;
            e_rst  = rel_rst;
            e_act  = rel_active;
            e_clk  = 1'b0;
            e_sel  = rel_sel;
        end
        check_val("busy", busy, e_busy);
        check_val("design_rst_n", design_rst_n, e_rst);
        check_val("active_id", active_id, e_act);
        check_val("sel_clk", sel_clk, e_clk);
        check_val("sel_id", sel_id, e_sel);
        if (running) begin
            if (edge_now) begin
                pend_v  = 1'b1;
                pend_id = edge_id;
            end
        end else if (edge_now) begin
            start_seq(c, edge_id);
        end else if (pend_v) begin
            start_seq(c, pend_id);
        end
    endtask

    always @(negedge wb_clk_i) if (mon_en) model_step();

    always @(negedge wb_clk_i) begin
        if (mon_en && sel_clk) begin
            pulse_cnt++;
            if (t4_phase && sel_id == 4'd3) seen3 = 1'b1;
        end
    end

    task automatic do_req(input logic [3:0] id, input int hi, input int lo);
        @(negedge wb_clk_i);
        la_id  = id;
        la_req = 1'b1;
        dq_d.push_back(cyc + 2);
        dq_id.push_back(id);
        repeat (hi) @(negedge wb_clk_i);
        la_req = 1'b0;
        repeat (lo) @(negedge wb_clk_i);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((running || pend_v || dq_d.size() > 0) && k < 400) begin
            @(negedge wb_clk_i);
            k++;
        end
        repeat (3) @(negedge wb_clk_i);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_sel_id"}, sel_id, PARK);
        check_val({pfx, "_sel_clk"}, sel_clk, 1'b0);
        check_val({pfx, "_design_rst_n"}, design_rst_n, 4'b0000);
        check_val({pfx, "_busy"}, busy, 1'b0);
        check_val({pfx, "_active_id"}, active_id, PARK);
    endtask

    int p0;
    logic [3:0] rid;

    initial begin
        // Reset, then idle with no request.
        repeat (3) @(negedge wb_clk_i);
        check_reset_vals("rst");
        wb_rst_n = 1'b1;
        #1 mon_en = 1'b1;
        repeat (20) @(negedge wb_clk_i);

        // Single switch to id 2.
        p0 = pulse_cnt;
        do_req(4'd2, 4, 3);
        drain();
        check_val("t2_rst", design_rst_n, 4'b0100);
        check_val("t2_active", active_id, 4'd2);
        check_val("t2_pulses", pulse_cnt - p0, 2);

        // Out-of-range id parks.
        p0 = pulse_cnt;
        do_req(4'd9, 4, 3);
        drain();
        check_val("t3_pulses", pulse_cnt - p0, 1);
        check_val("t3_rst", design_rst_n, 4'b0000);
        check_val("t3_sel", sel_id, PARK);
        check_val("t3_active", active_id, PARK);

        // Requests during HOLD: last one wins.
        t4_phase = 1'b1;
        do_req(4'd1, 4, 3);
        repeat (18) @(negedge wb_clk_i);
        do_req(4'd3, 3, 3);
        do_req(4'd0, 3, 3);
        drain();
        t4_phase = 1'b0;
        check_val("t4_active", active_id, 4'd0);
        check_val("t4_rst", design_rst_n, 4'b0001);
        check_val("t4_seen3", seen3, 1'b0);

        // Random traffic, including requests arriving mid-sequence.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) rid = 4'($urandom_range(4, 15));
            else rid = 4'($urandom_range(0, 3));
            do_req(rid, $urandom_range(1, 5), $urandom_range(3, 45));
        end
        drain();

        // Async reset during QUIESCE.
        @(negedge wb_clk_i);
        la_id  = 4'd3;
        la_req = 1'b1;
        dq_d.push_back(cyc + 2);
        dq_id.push_back(4'd3);
        repeat (4) @(negedge wb_clk_i);
        la_req = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        #2;
        mon_en   = 1'b0;
        wb_rst_n = 1'b0;
        #1;
        check_reset_vals("t5");
        running    = 1'b0;
        pend_v     = 1'b0;
        rel_rst    = '0;
        rel_active = PARK;
        rel_sel    = PARK;
        dq_d.delete();
        dq_id.delete();
        repeat (5) @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        #1 mon_en = 1'b1;
        p0 = pulse_cnt;
        repeat (60) @(negedge wb_clk_i);
        check_val("t5_pulses", pulse_cnt - p0, 0);

        // la_req held high, then a glitch that never spans a clock edge.
        p0 = pulse_cnt;
        @(negedge wb_clk_i);
        la_id  = 4'd1;
        la_req = 1'b1;
        dq_d.push_back(cyc + 2);
        dq_id.push_back(4'd1);
        repeat (100) @(negedge wb_clk_i);
        #1 la_req = 1'b0;
        #2 la_req = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        la_req = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        drain();
        check_val("t6_pulses", pulse_cnt - p0, 2);
        check_val("t6_active", active_id, 4'd1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
